// File: rtl/toll_payment_unit.sv
// Booth-side payment front end. Detects a vehicle, collects coin credit and
// issues a one-cycle car/pay_ok request to the gate controller once the fee is
// covered. It then follows the gate open/close pulses, returns change or
// refunds, and counts paid passages. All outputs come straight from registers.
module toll_payment_unit #(
    parameter logic [7:0]  FEE     = 8'd20,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        car_present_i,
    input  logic        coin_valid_i,
    input  logic [7:0]  coin_value_i,
    input  logic        cancel_i,
    input  logic        gate_open_i,
    input  logic        gate_close_i,
    output logic        car_o,
    output logic        pay_ok_o,
    output logic [7:0]  credit_o,
    output logic [7:0]  change_o,
    output logic        change_valid_o,
    output logic        refund_o,
    output logic        coin_reject_o,
    output logic        busy_o,
    output logic [15:0] paid_count_o
);

    // Counter only has to reach TIMEOUT-1; the expiring cycle itself leaves COLLECT.
    localparam int unsigned    TmoW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StRequest,
        StWaitOpen,
        StWaitClose,
        StRefund
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      credit_q, credit_d;
    logic [7:0]      change_q, change_d;
    logic            change_valid_q, change_valid_d;
    logic            refund_q, refund_d;
    logic            coin_reject_q, coin_reject_d;
    logic            car_q, car_d;
    logic            pay_ok_q, pay_ok_d;
    logic            busy_q, busy_d;
    logic [15:0]     paid_count_q, paid_count_d;
    logic [TmoW-1:0] tmo_q, tmo_d;

    logic [8:0]      credit_sum;
    logic [7:0]      credit_acc;
    logic            go_refund;

    // Credit after the current coin (if any), saturated at 255.
    always_comb begin
        credit_sum = {1'b0, credit_q} + {1'b0, coin_value_i};
        if (coin_valid_i) begin
            credit_acc = credit_sum[8] ? 8'hFF : credit_sum[7:0];
        end else begin
            credit_acc = credit_q;
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        change_d       = 8'd0;
        change_valid_d = 1'b0;
        refund_d       = 1'b0;
        car_d          = 1'b0;
        pay_ok_d       = 1'b0;
        paid_count_d   = paid_count_q;
        tmo_d          = '0;
        go_refund      = 1'b0;
        // Coins are only taken while collecting; anywhere else they bounce.
        coin_reject_d  = coin_valid_i && (state_q != StCollect);

        unique case (state_q)
            StIdle: begin
                if (car_present_i) begin
                    state_d = StCollect;
                end
            end

            StCollect: begin
                credit_d = credit_acc;
                tmo_d    = coin_valid_i ? '0 : tmo_q + 1'b1;
                // Cancel / sensor drop beat the fee check; a coin beats the timeout.
                if (cancel_i || !car_present_i) begin
                    go_refund = 1'b1;
                end else if (coin_valid_i && (credit_acc >= FEE)) begin
                    state_d  = StRequest;
                    car_d    = 1'b1;
                    pay_ok_d = 1'b1;
                    tmo_d    = '0;
                end else if (!coin_valid_i && (tmo_q == TmoLast)) begin
                    go_refund = 1'b1;
                end

                if (go_refund) begin
                    state_d        = StRefund;
                    change_d       = credit_acc;
                    change_valid_d = 1'b1;
                    refund_d       = 1'b1;
                    credit_d       = 8'd0;
                    tmo_d          = '0;
                end
            end

            StRequest: begin
                state_d = StWaitOpen;
            end

            StWaitOpen: begin
                // No timeout here: the gate may legitimately hold before opening.
                if (gate_open_i) begin
                    state_d        = StWaitClose;
                    change_d       = credit_q - FEE;
                    change_valid_d = (credit_q != FEE);
                    credit_d       = 8'd0;
                    if (paid_count_q != 16'hFFFF) begin
                        paid_count_d = paid_count_q + 16'd1;
                    end
                end
            end

            StWaitClose: begin
                if (gate_close_i) begin
                    state_d = StIdle;
                end
            end

            StRefund: begin
                state_d = StIdle;
            end

            default: begin
                state_d  = StIdle;
                credit_d = 8'd0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q        <= StIdle;
            credit_q       <= 8'd0;
            change_q       <= 8'd0;
            change_valid_q <= 1'b0;
            refund_q       <= 1'b0;
            coin_reject_q  <= 1'b0;
            car_q          <= 1'b0;
            pay_ok_q       <= 1'b0;
            busy_q         <= 1'b0;
            paid_count_q   <= 16'd0;
            tmo_q          <= '0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            refund_q       <= refund_d;
            coin_reject_q  <= coin_reject_d;
            car_q          <= car_d;
            pay_ok_q       <= pay_ok_d;
            busy_q         <= busy_d;
            paid_count_q   <= paid_count_d;
            tmo_q          <= tmo_d;
        end
    end

    assign car_o          = car_q;
    assign pay_ok_o       = pay_ok_q;
    assign credit_o       = credit_q;
    assign change_o       = change_q;
    assign change_valid_o = change_valid_q;
    assign refund_o       = refund_q;
    assign coin_reject_o  = coin_reject_q;
    assign busy_o         = busy_q;
    assign paid_count_o   = paid_count_q;

endmodule

// File: tb/tb_toll_payment_unit.sv
// Directed bench for toll_payment_unit: a FEE=20 instance for the main flows and
// a FEE=255 instance for credit saturation.
module tb_toll_payment_unit;

    logic        clk;
    logic        reset_ni;

    logic        car_present, coin_valid, cancel, gate_open, gate_close;
    logic [7:0]  coin_value;
    logic        car_o, pay_ok_o, change_valid_o, refund_o, coin_reject_o, busy_o;
    logic [7:0]  credit_o, change_o;
    logic [15:0] paid_count_o;

    logic        s_car_present, s_coin_valid, s_cancel, s_gate_open, s_gate_close;
    logic [7:0]  s_coin_value;
    logic        s_car_o, s_pay_ok_o, s_change_valid_o, s_refund_o, s_coin_reject_o, s_busy_o;
    logic [7:0]  s_credit_o, s_change_o;
    logic [15:0] s_paid_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    toll_payment_unit #(.FEE(8'd20), .TIMEOUT(16)) dut (
        .clk_i          (clk),
        .reset_ni       (reset_ni),
        .car_present_i  (car_present),
        .coin_valid_i   (coin_valid),
        .coin_value_i   (coin_value),
        .cancel_i       (cancel),
        .gate_open_i    (gate_open),
        .gate_close_i   (gate_close),
        .car_o          (car_o),
        .pay_ok_o       (pay_ok_o),
        .credit_o       (credit_o),
        .change_o       (change_o),
        .change_valid_o (change_valid_o),
        .refund_o       (refund_o),
        .coin_reject_o  (coin_reject_o),
        .busy_o         (busy_o),
        .paid_count_o   (paid_count_o)
    );

    toll_payment_unit #(.FEE(8'd255), .TIMEOUT(16)) dut_sat (
        .clk_i          (clk),
        .reset_ni       (reset_ni),
        .car_present_i  (s_car_present),
        .coin_valid_i   (s_coin_valid),
        .coin_value_i   (s_coin_value),
        .cancel_i       (s_cancel),
        .gate_open_i    (s_gate_open),
        .gate_close_i   (s_gate_close),
        .car_o          (s_car_o),
        .pay_ok_o       (s_pay_ok_o),
        .credit_o       (s_credit_o),
        .change_o       (s_change_o),
        .change_valid_o (s_change_valid_o),
        .refund_o       (s_refund_o),
        .coin_reject_o  (s_coin_reject_o),
        .busy_o         (s_busy_o),
        .paid_count_o   (s_paid_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are looked at 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        car_present = 0; coin_valid = 0; coin_value = 0; cancel = 0;
        gate_open = 0; gate_close = 0;
        s_car_present = 0; s_coin_valid = 0; s_coin_value = 0; s_cancel = 0;
        s_gate_open = 0; s_gate_close = 0;
        tick();
        tick();
        n_checks++;
        if ({car_o, pay_ok_o, credit_o, change_o, change_valid_o, refund_o, coin_reject_o,
             busy_o, paid_count_o} !== 41'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got car=%b ok=%b cr=%0d ch=%0d cv=%b rf=%b rj=%b bz=%b pc=%0d want all 0",
                     car_o, pay_ok_o, credit_o, change_o, change_valid_o, refund_o,
                     coin_reject_o, busy_o, paid_count_o);
        end
        reset_ni = 1'b1;
        tick();
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %b want 0", busy_o);
        end
    endtask

    task automatic test_exact_fee();
        car_present = 1;
        tick();
        n_checks++;
        if ({busy_o, credit_o} !== {1'b1, 8'd0}) begin
            n_fail++;
            $display("FAIL exact_enter_collect: got busy=%b credit=%0d want 1/0", busy_o, credit_o);
        end
        coin_valid = 1; coin_value = 8'd10;
        tick();
        n_checks++;
        if ({car_o, credit_o} !== {1'b0, 8'd10}) begin
            n_fail++;
            $display("FAIL exact_first_coin: got car=%b credit=%0d want 0/10", car_o, credit_o);
        end
        tick();
        n_checks++;
        if ({car_o, pay_ok_o, credit_o} !== {1'b1, 1'b1, 8'd20}) begin
            n_fail++;
            $display("FAIL exact_request: got car=%b ok=%b credit=%0d want 1/1/20",
                     car_o, pay_ok_o, credit_o);
        end
        coin_valid = 0; car_present = 0;
        tick();
        n_checks++;
        if ({car_o, pay_ok_o, busy_o} !== 3'b001) begin
            n_fail++;
            $display("FAIL exact_request_one_cycle: got car=%b ok=%b busy=%b want 0/0/1",
                     car_o, pay_ok_o, busy_o);
        end
        repeat (3) tick();
        n_checks++;
        if ({busy_o, paid_count_o} !== {1'b1, 16'd0}) begin
            n_fail++;
            $display("FAIL exact_wait_open: got busy=%b paid=%0d want 1/0", busy_o, paid_count_o);
        end
        gate_open = 1;
        tick();
        gate_open = 0;
        n_checks++;
        if ({paid_count_o, change_valid_o, credit_o} !== {16'd1, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL exact_gate_open: got paid=%0d cv=%b credit=%0d want 1/0/0",
                     paid_count_o, change_valid_o, credit_o);
        end
        tick();
        n_checks++;
        if ({busy_o, change_valid_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL exact_wait_close: got busy=%b cv=%b want 1/0", busy_o, change_valid_o);
        end
        gate_close = 1;
        tick();
        gate_close = 0;
        n_checks++;
        if ({busy_o, credit_o} !== {1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL exact_close_idle: got busy=%b credit=%0d want 0/0", busy_o, credit_o);
        end
    endtask

    task automatic test_overpay();
        car_present = 1;
        tick();
        coin_valid = 1; coin_value = 8'd5;
        tick();
        coin_value = 8'd20;
        tick();
        n_checks++;
        if ({car_o, pay_ok_o, credit_o} !== {1'b1, 1'b1, 8'd25}) begin
            n_fail++;
            $display("FAIL overpay_request: got car=%b ok=%b credit=%0d want 1/1/25",
                     car_o, pay_ok_o, credit_o);
        end
        coin_valid = 0; car_present = 0;
        tick();
        gate_open = 1;
        tick();
        gate_open = 0;
        n_checks++;
        if ({change_valid_o, change_o, paid_count_o, credit_o} !== {1'b1, 8'd5, 16'd2, 8'd0}) begin
            n_fail++;
            $display("FAIL overpay_change: got cv=%b change=%0d paid=%0d credit=%0d want 1/5/2/0",
                     change_valid_o, change_o, paid_count_o, credit_o);
        end
        tick();
        n_checks++;
        if ({change_valid_o, refund_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL overpay_change_pulse: got cv=%b rf=%b want 0/0", change_valid_o, refund_o);
        end
        gate_close = 1;
        tick();
        gate_close = 0;
    endtask

    task automatic test_timeout();
        car_present = 1;
        tick();
        coin_valid = 1; coin_value = 8'd10;
        tick();
        coin_valid = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            n_checks++;
            if ({car_o, change_valid_o, refund_o, busy_o} !== 4'b0001) begin
                n_fail++;
                $display("FAIL timeout_early_%0d: got car=%b cv=%b rf=%b busy=%b want 0/0/0/1",
                         i, car_o, change_valid_o, refund_o, busy_o);
            end
        end
        tick();
        n_checks++;
        if ({change_valid_o, refund_o, change_o, car_o, credit_o} !== {2'b11, 8'd10, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL timeout_refund: got cv=%b rf=%b change=%0d car=%b credit=%0d want 1/1/10/0/0",
                     change_valid_o, refund_o, change_o, car_o, credit_o);
        end
        car_present = 0;
        tick();
        n_checks++;
        if ({busy_o, refund_o, change_valid_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL timeout_idle: got busy=%b rf=%b cv=%b want 0/0/0",
                     busy_o, refund_o, change_valid_o);
        end
    endtask

    task automatic test_cancel_collision();
        car_present = 1;
        tick();
        coin_valid = 1; coin_value = 8'd10;
        tick();
        cancel = 1; coin_value = 8'd5;
        tick();
        cancel = 0; coin_valid = 0; car_present = 0;
        n_checks++;
        if ({change_valid_o, refund_o, change_o, car_o, paid_count_o} !==
            {2'b11, 8'd15, 1'b0, 16'd2}) begin
            n_fail++;
            $display("FAIL cancel_refund: got cv=%b rf=%b change=%0d car=%b paid=%0d want 1/1/15/0/2",
                     change_valid_o, refund_o, change_o, car_o, paid_count_o);
        end
        tick();
        n_checks++;
        if ({busy_o, credit_o} !== {1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL cancel_idle: got busy=%b credit=%0d want 0/0", busy_o, credit_o);
        end
    endtask

    task automatic test_rejects();
        coin_valid = 1; coin_value = 8'd7;
        tick();
        coin_valid = 0;
        n_checks++;
        if ({coin_reject_o, credit_o, busy_o} !== {1'b1, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reject_idle: got rj=%b credit=%0d busy=%b want 1/0/0",
                     coin_reject_o, credit_o, busy_o);
        end
        tick();
        n_checks++;
        if (coin_reject_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reject_idle_pulse: got %b want 0", coin_reject_o);
        end
        car_present = 1;
        tick();
        coin_valid = 1; coin_value = 8'd20;
        tick();
        coin_valid = 0; car_present = 0;
        tick();
        coin_valid = 1; coin_value = 8'd3;
        tick();
        coin_valid = 0;
        n_checks++;
        if ({coin_reject_o, credit_o, busy_o} !== {1'b1, 8'd20, 1'b1}) begin
            n_fail++;
            $display("FAIL reject_wait_open: got rj=%b credit=%0d busy=%b want 1/20/1",
                     coin_reject_o, credit_o, busy_o);
        end
        cancel = 1;
        tick();
        cancel = 0;
        n_checks++;
        if ({coin_reject_o, refund_o, change_valid_o, busy_o} !== 4'b0001) begin
            n_fail++;
            $display("FAIL wait_open_ignores_cancel: got rj=%b rf=%b cv=%b busy=%b want 0/0/0/1",
                     coin_reject_o, refund_o, change_valid_o, busy_o);
        end
    endtask

    task automatic test_saturation();
        s_car_present = 1;
        tick();
        s_coin_valid = 1; s_coin_value = 8'd200;
        tick();
        n_checks++;
        if ({s_car_o, s_credit_o} !== {1'b0, 8'd200}) begin
            n_fail++;
            $display("FAIL sat_first_coin: got car=%b credit=%0d want 0/200", s_car_o, s_credit_o);
        end
        tick();
        s_coin_valid = 0; s_car_present = 0;
        n_checks++;
        if ({s_car_o, s_pay_ok_o, s_credit_o} !== {1'b1, 1'b1, 8'd255}) begin
            n_fail++;
            $display("FAIL sat_request: got car=%b ok=%b credit=%0d want 1/1/255",
                     s_car_o, s_pay_ok_o, s_credit_o);
        end
        tick();
        s_gate_open = 1;
        tick();
        s_gate_open = 0;
        n_checks++;
        if ({s_paid_count_o, s_change_valid_o} !== {16'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL sat_gate_open: got paid=%0d cv=%b want 1/0", s_paid_count_o, s_change_valid_o);
        end
        s_gate_close = 1;
        tick();
        s_gate_close = 0;
    endtask

    // Main DUT is parked in WAIT_OPEN with credit 20 and two passages paid.
    task automatic test_reset_mid();
        @(negedge clk);
        #2;
        reset_ni = 1'b0;
        #1;
        n_checks++;
        if ({car_o, pay_ok_o, credit_o, change_o, change_valid_o, refund_o, coin_reject_o,
             busy_o, paid_count_o} !== 41'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got cr=%0d bz=%b pc=%0d cv=%b rf=%b want all 0",
                     credit_o, busy_o, paid_count_o, change_valid_o, refund_o);
        end
        tick();
        reset_ni = 1'b1;
        car_present = 1;
        tick();
        n_checks++;
        if ({busy_o, credit_o, refund_o} !== {1'b1, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_fresh: got busy=%b credit=%0d rf=%b want 1/0/0",
                     busy_o, credit_o, refund_o);
        end
        coin_valid = 1; coin_value = 8'd5;
        tick();
        coin_valid = 0;
        n_checks++;
        if ({credit_o, paid_count_o} !== {8'd5, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_credit: got credit=%0d paid=%0d want 5/0", credit_o, paid_count_o);
        end
        cancel = 1;
        tick();
        cancel = 0; car_present = 0;
        n_checks++;
        if ({refund_o, change_o} !== {1'b1, 8'd5}) begin
            n_fail++;
            $display("FAIL reset_mid_refund: got rf=%b change=%0d want 1/5", refund_o, change_o);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_exact_fee();
        test_overpay();
        test_timeout();
        test_cancel_collision();
        test_rejects();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want end before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
